// File: rtl/fetch_if_id_stage.sv
// Small circular FIFO with synchronous clear; head is combinational from storage.
// Latency: push visible at head one cycle later; no bypass.
// Backpressure: none internally -- callers guarantee no push when full, no pop when empty.
module fetch_if_id_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push_vld,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop_vld,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop_vld) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(i_push_vld) - (AW+1)'(i_pop_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push_vld && !i_clr) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

// Fetch stage + IF/ID register: issues in-order imem requests, tags them with an epoch,
// buffers matching responses and feeds decode. Latency: request -> decode >= 3 cycles.
// Backpressure: credits (outstanding + buffered < FIFO_DEPTH) gate requests; stall_d holds IF/ID.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);
    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_pc_f;
    logic          r_epoch;
    logic [31:0]   r_instr_d;
    logic [31:0]   r_pc_d;
    logic [31:0]   r_pc_plus4_d;
    logic          r_valid_d;

    logic [CW-1:0] w_outstanding;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_used;
    logic [32:0]   w_tag_head;
    logic [63:0]   w_ins_head;
    logic          w_req_fire;
    logic          w_rsp_ok;
    logic          w_ins_push;
    logic          w_ins_pop;
    logic [31:0]   w_redir_pc;

    assign w_credit_used  = {1'b0, w_outstanding} + {1'b0, w_count};
    assign imem_req_valid = !rst && !redirect_valid && (w_credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc_f;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding has no tag to match and is ignored.
    assign w_rsp_ok       = imem_rsp_valid && (w_outstanding != '0);
    assign w_ins_push     = w_rsp_ok && !redirect_valid && (w_tag_head[32] == r_epoch);
    assign w_ins_pop      = !redirect_valid && !stall_d && (w_count != '0);
    assign w_redir_pc     = redirect_pc & 32'hFFFF_FFFC;

    fetch_if_id_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (1'b0),
        .i_push_vld (w_req_fire),
        .i_push_dat ({r_epoch, r_pc_f}),
        .i_pop_vld  (w_rsp_ok),
        .o_head_dat (w_tag_head),
        .o_count    (w_outstanding)
    );

    fetch_if_id_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_ins_q (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (redirect_valid),
        .i_push_vld (w_ins_push),
        .i_push_dat ({w_tag_head[31:0], imem_rsp_data}),
        .i_pop_vld  (w_ins_pop),
        .o_head_dat (w_ins_head),
        .o_count    (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f  <= RESET_PC;
            r_epoch <= 1'b0;
        end else if (redirect_valid) begin
            r_pc_f  <= w_redir_pc;
            r_epoch <= ~r_epoch;
        end else if (w_req_fire) begin
            r_pc_f  <= r_pc_f + 32'd4;
        end
    end

    // Bubbles keep pc_d/pc_plus4_d so a flushed slot still reports its last PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d    <= NOP;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (redirect_valid || (!stall_d && (w_count == '0))) begin
            r_instr_d    <= NOP;
            r_valid_d    <= 1'b0;
        end else if (w_ins_pop) begin
            r_instr_d    <= w_ins_head[31:0];
            r_pc_d       <= w_ins_head[63:32];
            r_pc_plus4_d <= w_ins_head[63:32] + 32'd4;
            r_valid_d    <= 1'b1;
        end
    end

    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
endmodule
